sequencer: RTL and testbench
============================

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter OPCODE_W, default 4: instruction opcode width, minimum 4.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 Port clk, input, 1: single clock; all state changes on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port instruction, input, OPCODE_W: opcode currently held in the instruction register.
REQ-006 Port overflow / zero, input, 1 each: ALU flags.
REQ-007 Port mem_ready, input, 1: memory completes the current access this cycle.
REQ-008 Port ctrl, output, ctrl_t: packed control word.
- Fields: ir_low, ir_high, acc_low, acc_high, temp_register, pc, mp16, swap_register, alu_data, alu_mem (reg_op_t); alu_mem_mode (memalu_op_t); overflow_read, zero_read, mp8_low, mp8_high, address_read, data_in, data_out, mem_enable (1 bit).
REQ-009 Port halted, output, 1: high while in HALT.
REQ-010 Port illegal, output, 1: one-cycle pulse on an undefined opcode.
REQ-011 Port retired, output, CNT_W: instructions completed (present only under SEQ_RETIRE_CNT_EN).

Function
REQ-012 Control outputs SHALL be combinational from state only; defaults SHALL be REG_OP_NONE, 0, and MEMALU_OP_ADD.
REQ-013 Opcode decode SHALL occur in INCPC_B:
- 0 ASTL, 1 ASTH, 2 MSTL, 3 MSTH, 4 OPER
- 6 JMP, 7 JMZ, 8 JMO
- 9 LOD, A STO, B SWP, C MADD, F HLT
- Any other value, including nonzero bits above bit 3, is illegal.
REQ-014 Fetch path SHALL be FETCH_A -> FETCH_C -> INCPC_A -> INCPC_B.
- FETCH_A: pc WRITE, address_read.
- FETCH_C: data_in, mem_enable, ir_low/ir_high READ.
- INCPC_A: pc WRITE, alu_mem READ, mode INCR.
- INCPC_B: alu_mem WRITE, mode INCR, pc READ.
REQ-015 FETCH_C, LOD_C and STO_C SHALL hold their outputs and state until mem_ready=1, then advance. Wait length is unbounded.
REQ-016 AST_L / AST_H: ir_low WRITE; acc_low / acc_high READ respectively; then -> FETCH_A.
REQ-017 MST_L / MST_H: acc_low and acc_high WRITE; mp8_low / mp8_high respectively; then -> FETCH_A.
REQ-018 OPER_A: acc WRITE, alu_data READ. OPER_B: alu_data WRITE, acc READ, overflow_read, zero_read; then -> FETCH_A.
REQ-019 LOD_A and STO_A: ir_low SWRITENC, mp16 WRITE, alu_mem READ, mode OFFSET.
- LOD_B / STO_B: alu_mem WRITE, address_read.
- LOD_C: data_in, mem_enable, acc READ.
- STO_C: data_out, mem_enable, acc WRITE.
REQ-020 SWP_A: temp WRITE, swap READ. SWP_B: acc WRITE, temp READ. SWP_C: swap WRITE, acc READ.
REQ-021 MADD_A: acc WRITE, mp16 WRITE, alu_mem READ. MADD_B: alu_mem WRITE, mp16 READ.
REQ-022 JMP_A: acc WRITE, pc WRITE, alu_mem READ, mode OFFSET. JMP_B: alu_mem WRITE, mode OFFSET, pc READ.
REQ-023 JMZ SHALL enter JMP_A only if zero=1, and JMO only if overflow=1, with flags sampled in INCPC_B; otherwise -> FETCH_A.
REQ-024 An illegal opcode SHALL pulse illegal in the cycle after INCPC_B and SHALL return to FETCH_A as a no-op.
REQ-025 HLT SHALL enter HALT; halted=1, all controls at default; HALT is left only by reset.
REQ-026 An instruction SHALL retire on each final-state exit to FETCH_A, including not-taken jumps and illegal no-ops. Entry to HALT also counts as a retire.

Reset
REQ-027 reset=1 SHALL force FETCH_A on the next edge from any state, including mid memory wait and HALT.
REQ-028 On reset: halted=0, illegal=0, retired=0; reset has priority over every transition.

Configuration
REQ-029 With SEQ_RETIRE_CNT_EN defined, retired SHALL increment once per retire and wrap from all-ones to 0.
REQ-030 Without SEQ_RETIRE_CNT_EN, the port and the counter SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-031 Package seq_pkg SHALL hold: ctrl_t, the state enum (5 bits), opcode localparams, and the reuse of reg_op_t / memalu_op_t.
REQ-032 No sub-module SHALL be used; next-state logic and output decode are separate combinational processes.

Verification
REQ-033 ASTL, mem_ready always 1: states FETCH_A, FETCH_C, INCPC_A, INCPC_B, AST_L, FETCH_A over 5 cycles; retired=1.
REQ-034 LOD with mem_ready low for 3 cycles in LOD_C: LOD_C held 4 cycles, acc READ asserted throughout, then FETCH_A.
REQ-035 JMZ with zero=0: back to FETCH_A after INCPC_B. JMZ with zero=1: JMP_A, JMP_B, then FETCH_A.
REQ-036 Opcode 5, and opcode 0x14 with OPCODE_W=5: illegal high exactly 1 cycle, then fetch resumes.
REQ-037 HLT followed by 10 cycles: halted stays 1. Reset asserted during STO_C wait: FETCH_A next cycle, retired=0.
REQ-038 CNT_W=4 with the macro defined: 17 retires give retired=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: control word, state encoding,
// opcode values and the idle control word.
package seq_pkg;

   typedef enum logic [1:0] {
      REG_OP_NONE     = 2'd0,
      REG_OP_READ     = 2'd1,
      REG_OP_WRITE    = 2'd2,
      REG_OP_SWRITENC = 2'd3
   } reg_op_t;

   typedef enum logic [1:0] {
      MEMALU_OP_ADD    = 2'd0,
      MEMALU_OP_INCR   = 2'd1,
      MEMALU_OP_OFFSET = 2'd2
   } memalu_op_t;

   typedef struct packed {
      reg_op_t    ir_low;
      reg_op_t    ir_high;
      reg_op_t    acc_low;
      reg_op_t    acc_high;
      reg_op_t    temp_register;
      reg_op_t    pc;
      reg_op_t    mp16;
      reg_op_t    swap_register;
      reg_op_t    alu_data;
      reg_op_t    alu_mem;
      memalu_op_t alu_mem_mode;
      logic       overflow_read;
      logic       zero_read;
      logic       mp8_low;
      logic       mp8_high;
      logic       address_read;
      logic       data_in;
      logic       data_out;
      logic       mem_enable;
   } ctrl_t;

   typedef enum logic [4:0] {
      FETCH_A = 5'd0,  FETCH_C = 5'd1,  INCPC_A = 5'd2,  INCPC_B = 5'd3,
      AST_L   = 5'd4,  AST_H   = 5'd5,  MST_L   = 5'd6,  MST_H   = 5'd7,
      OPER_A  = 5'd8,  OPER_B  = 5'd9,  LOD_A   = 5'd10, LOD_B   = 5'd11,
      LOD_C   = 5'd12, STO_A   = 5'd13, STO_B   = 5'd14, STO_C   = 5'd15,
      SWP_A   = 5'd16, SWP_B   = 5'd17, SWP_C   = 5'd18, MADD_A  = 5'd19,
      MADD_B  = 5'd20, JMP_A   = 5'd21, JMP_B   = 5'd22, HALT    = 5'd23
   } state_t;

   localparam logic [3:0] OP_ASTL = 4'h0;
   localparam logic [3:0] OP_ASTH = 4'h1;
   localparam logic [3:0] OP_MSTL = 4'h2;
   localparam logic [3:0] OP_MSTH = 4'h3;
   localparam logic [3:0] OP_OPER = 4'h4;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JMZ  = 4'h7;
   localparam logic [3:0] OP_JMO  = 4'h8;
   localparam logic [3:0] OP_LOD  = 4'h9;
   localparam logic [3:0] OP_STO  = 4'hA;
   localparam logic [3:0] OP_SWP  = 4'hB;
   localparam logic [3:0] OP_MADD = 4'hC;
   localparam logic [3:0] OP_HLT  = 4'hF;

   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c = '0;
      c.alu_mem_mode = MEMALU_OP_ADD;
      return c;
   endfunction

endpackage

// File: rtl/sequencer.sv
// Microcoded control sequencer: fetch, decode and per-opcode control steps.
// Optional retired-instruction counter enabled by defining SEQ_RETIRE_CNT_EN.
module sequencer
   import seq_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] instruction,
   input  logic                overflow,
   input  logic                zero,
   input  logic                mem_ready,
   output ctrl_t               ctrl,
   output logic                halted,
   output logic                illegal
`ifdef SEQ_RETIRE_CNT_EN
   ,
   output logic [CNT_W-1:0]    retired
`endif
);

   state_t     r_state;
   state_t     w_next;
   logic       r_illegal;
   logic       w_illegal;
   logic [3:0] w_op;
   logic       w_hi_nz;
   ctrl_t      w_ctrl;

   assign w_op    = instruction[3:0];
   assign w_hi_nz = (instruction >> 4) != '0;

   always_comb begin
      w_next    = r_state;
      w_illegal = 1'b0;
      case (r_state)
         FETCH_A: w_next = FETCH_C;
         FETCH_C: if (mem_ready) w_next = INCPC_A; else w_next = FETCH_C;
         INCPC_A: w_next = INCPC_B;
         INCPC_B: begin
            if (w_hi_nz) begin
               w_next    = FETCH_A;
               w_illegal = 1'b1;
            end else begin
               case (w_op)
                  OP_ASTL: w_next = AST_L;
                  OP_ASTH: w_next = AST_H;
                  OP_MSTL: w_next = MST_L;
                  OP_MSTH: w_next = MST_H;
                  OP_OPER: w_next = OPER_A;
                  OP_JMP:  w_next = JMP_A;
                  OP_JMZ:  if (zero) w_next = JMP_A; else w_next = FETCH_A;
                  OP_JMO:  if (overflow) w_next = JMP_A; else w_next = FETCH_A;
                  OP_LOD:  w_next = LOD_A;
                  OP_STO:  w_next = STO_A;
                  OP_SWP:  w_next = SWP_A;
                  OP_MADD: w_next = MADD_A;
                  OP_HLT:  w_next = HALT;
                  default: begin
                     w_next    = FETCH_A;
                     w_illegal = 1'b1;
                  end
               endcase
            end
         end
         OPER_A:  w_next = OPER_B;
         LOD_A:   w_next = LOD_B;
         LOD_B:   w_next = LOD_C;
         LOD_C:   if (mem_ready) w_next = FETCH_A; else w_next = LOD_C;
         STO_A:   w_next = STO_B;
         STO_B:   w_next = STO_C;
         STO_C:   if (mem_ready) w_next = FETCH_A; else w_next = STO_C;
         SWP_A:   w_next = SWP_B;
         SWP_B:   w_next = SWP_C;
         MADD_A:  w_next = MADD_B;
         JMP_A:   w_next = JMP_B;
         HALT:    w_next = HALT;
         default: w_next = FETCH_A;
      endcase
   end

   // The illegal flag is registered so it pulses in the cycle after decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= FETCH_A;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_illegal <= w_illegal;
      end
   end

   always_comb begin
      w_ctrl = ctrl_idle();
      case (r_state)
         FETCH_A: begin
            w_ctrl.pc           = REG_OP_WRITE;
            w_ctrl.address_read = 1'b1;
         end
         FETCH_C: begin
            w_ctrl.data_in    = 1'b1;
            w_ctrl.mem_enable = 1'b1;
            w_ctrl.ir_low     = REG_OP_READ;
            w_ctrl.ir_high    = REG_OP_READ;
         end
         INCPC_A: begin
            w_ctrl.pc           = REG_OP_WRITE;
            w_ctrl.alu_mem      = REG_OP_READ;
            w_ctrl.alu_mem_mode = MEMALU_OP_INCR;
         end
         INCPC_B: begin
            w_ctrl.alu_mem      = REG_OP_WRITE;
            w_ctrl.alu_mem_mode = MEMALU_OP_INCR;
            w_ctrl.pc           = REG_OP_READ;
         end
         AST_L: begin
            w_ctrl.ir_low  = REG_OP_WRITE;
            w_ctrl.acc_low = REG_OP_READ;
         end
         AST_H: begin
            w_ctrl.ir_low   = REG_OP_WRITE;
            w_ctrl.acc_high = REG_OP_READ;
         end
         MST_L, MST_H: begin
            w_ctrl.acc_low  = REG_OP_WRITE;
            w_ctrl.acc_high = REG_OP_WRITE;
            w_ctrl.mp8_low  = (r_state == MST_L);
            w_ctrl.mp8_high = (r_state == MST_H);
         end
         OPER_A: begin
            w_ctrl.acc_low  = REG_OP_WRITE;
            w_ctrl.acc_high = REG_OP_WRITE;
            w_ctrl.alu_data = REG_OP_READ;
         end
         OPER_B: begin
            w_ctrl.alu_data      = REG_OP_WRITE;
            w_ctrl.acc_low       = REG_OP_READ;
            w_ctrl.acc_high      = REG_OP_READ;
            w_ctrl.overflow_read = 1'b1;
            w_ctrl.zero_read     = 1'b1;
         end
         LOD_A, STO_A: begin
            w_ctrl.ir_low       = REG_OP_SWRITENC;
            w_ctrl.mp16         = REG_OP_WRITE;
            w_ctrl.alu_mem      = REG_OP_READ;
            w_ctrl.alu_mem_mode = MEMALU_OP_OFFSET;
         end
         LOD_B, STO_B: begin
            w_ctrl.alu_mem      = REG_OP_WRITE;
            w_ctrl.address_read = 1'b1;
         end
         LOD_C: begin
            w_ctrl.data_in    = 1'b1;
            w_ctrl.mem_enable = 1'b1;
            w_ctrl.acc_low    = REG_OP_READ;
            w_ctrl.acc_high   = REG_OP_READ;
         end
         STO_C: begin
            w_ctrl.data_out   = 1'b1;
            w_ctrl.mem_enable = 1'b1;
            w_ctrl.acc_low    = REG_OP_WRITE;
            w_ctrl.acc_high   = REG_OP_WRITE;
         end
         SWP_A: begin
            w_ctrl.temp_register = REG_OP_WRITE;
            w_ctrl.swap_register = REG_OP_READ;
         end
         SWP_B: begin
            w_ctrl.acc_low       = REG_OP_WRITE;
            w_ctrl.acc_high      = REG_OP_WRITE;
            w_ctrl.temp_register = REG_OP_READ;
         end
         SWP_C: begin
            w_ctrl.swap_register = REG_OP_WRITE;
            w_ctrl.acc_low       = REG_OP_READ;
            w_ctrl.acc_high      = REG_OP_READ;
         end
         MADD_A: begin
            w_ctrl.acc_low  = REG_OP_WRITE;
            w_ctrl.acc_high = REG_OP_WRITE;
            w_ctrl.mp16     = REG_OP_WRITE;
            w_ctrl.alu_mem  = REG_OP_READ;
         end
         MADD_B: begin
            w_ctrl.alu_mem = REG_OP_WRITE;
            w_ctrl.mp16    = REG_OP_READ;
         end
         JMP_A: begin
            w_ctrl.acc_low      = REG_OP_WRITE;
            w_ctrl.acc_high     = REG_OP_WRITE;
            w_ctrl.pc           = REG_OP_WRITE;
            w_ctrl.alu_mem      = REG_OP_READ;
            w_ctrl.alu_mem_mode = MEMALU_OP_OFFSET;
         end
         JMP_B: begin
            w_ctrl.alu_mem      = REG_OP_WRITE;
            w_ctrl.alu_mem_mode = MEMALU_OP_OFFSET;
            w_ctrl.pc           = REG_OP_READ;
         end
         default: w_ctrl = ctrl_idle();
      endcase
   end

   assign ctrl    = w_ctrl;
   assign halted  = (r_state == HALT);
   assign illegal = r_illegal;

`ifdef SEQ_RETIRE_CNT_EN
   logic             w_retire;
   logic [CNT_W-1:0] r_retired;

   // Every path back to FETCH_A ends an instruction; entering HALT ends HLT.
   assign w_retire = (w_next == FETCH_A) || ((w_next == HALT) && (r_state != HALT));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + CNT_W'(1);
      end else begin
         r_retired <= r_retired;
      end
   end

   assign retired = r_retired;
`endif

endmodule

// File: tb/tb_sequencer.sv
// Scoreboard bench for sequencer: stimulus queues expected per-cycle state,
// a negedge monitor compares the control word, flags and retire count.
module tb_sequencer;
   import seq_pkg::*;

   localparam int OPW = 5;
   localparam int CW  = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [OPW-1:0] instruction = '0;
   logic           overflow = 1'b0;
   logic           zero = 1'b0;
   logic           mem_ready = 1'b1;
   ctrl_t          ctrl;
   logic           halted;
   logic           illegal;
`ifdef SEQ_RETIRE_CNT_EN
   logic [CW-1:0]  retired;
`endif

   sequencer #(.OPCODE_W(OPW), .CNT_W(CW)) dut (
      .clk(clk),
      .reset(reset),
      .instruction(instruction),
      .overflow(overflow),
      .zero(zero),
      .mem_ready(mem_ready),
      .ctrl(ctrl),
      .halted(halted),
      .illegal(illegal)
`ifdef SEQ_RETIRE_CNT_EN
      ,
      .retired(retired)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      state_t        st;
      logic          ill;
      logic [CW-1:0] ret;
   } exp_t;

   exp_t          q[$];
   int            checks = 0;
   int            failures = 0;
   logic [CW-1:0] exp_ret = '0;

   // Control word each state must present, transcribed from the state table.
   function automatic ctrl_t exp_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      c.alu_mem_mode = MEMALU_OP_ADD;
      case (s)
         FETCH_A: begin c.pc = REG_OP_WRITE; c.address_read = 1'b1; end
         FETCH_C: begin c.data_in = 1'b1; c.mem_enable = 1'b1;
                        c.ir_low = REG_OP_READ; c.ir_high = REG_OP_READ; end
         INCPC_A: begin c.pc = REG_OP_WRITE; c.alu_mem = REG_OP_READ;
                        c.alu_mem_mode = MEMALU_OP_INCR; end
         INCPC_B: begin c.alu_mem = REG_OP_WRITE; c.alu_mem_mode = MEMALU_OP_INCR;
                        c.pc = REG_OP_READ; end
         AST_L:   begin c.ir_low = REG_OP_WRITE; c.acc_low = REG_OP_READ; end
         AST_H:   begin c.ir_low = REG_OP_WRITE; c.acc_high = REG_OP_READ; end
         MST_L:   begin c.acc_low = REG_OP_WRITE; c.acc_high = REG_OP_WRITE; c.mp8_low = 1'b1; end
         MST_H:   begin c.acc_low = REG_OP_WRITE; c.acc_high = REG_OP_WRITE; c.mp8_high = 1'b1; end
         OPER_A:  begin c.acc_low = REG_OP_WRITE; c.acc_high = REG_OP_WRITE; c.alu_data = REG_OP_READ; end
         OPER_B:  begin c.alu_data = REG_OP_WRITE; c.acc_low = REG_OP_READ; c.acc_high = REG_OP_READ;
                        c.overflow_read = 1'b1; c.zero_read = 1'b1; end
         LOD_A, STO_A: begin c.ir_low = REG_OP_SWRITENC; c.mp16 = REG_OP_WRITE;
                        c.alu_mem = REG_OP_READ; c.alu_mem_mode = MEMALU_OP_OFFSET; end
         LOD_B, STO_B: begin c.alu_mem = REG_OP_WRITE; c.address_read = 1'b1; end
         LOD_C:   begin c.data_in = 1'b1; c.mem_enable = 1'b1;
                        c.acc_low = REG_OP_READ; c.acc_high = REG_OP_READ; end
         STO_C:   begin c.data_out = 1'b1; c.mem_enable = 1'b1;
                        c.acc_low = REG_OP_WRITE; c.acc_high = REG_OP_WRITE; end
         SWP_A:   begin c.temp_register = REG_OP_WRITE; c.swap_register = REG_OP_READ; end
         SWP_B:   begin c.acc_low = REG_OP_WRITE; c.acc_high = REG_OP_WRITE; c.temp_register = REG_OP_READ; end
         SWP_C:   begin c.swap_register = REG_OP_WRITE; c.acc_low = REG_OP_READ; c.acc_high = REG_OP_READ; end
         MADD_A:  begin c.acc_low = REG_OP_WRITE; c.acc_high = REG_OP_WRITE;
                        c.mp16 = REG_OP_WRITE; c.alu_mem = REG_OP_READ; end
         MADD_B:  begin c.alu_mem = REG_OP_WRITE; c.mp16 = REG_OP_READ; end
         JMP_A:   begin c.acc_low = REG_OP_WRITE; c.acc_high = REG_OP_WRITE; c.pc = REG_OP_WRITE;
                        c.alu_mem = REG_OP_READ; c.alu_mem_mode = MEMALU_OP_OFFSET; end
         JMP_B:   begin c.alu_mem = REG_OP_WRITE; c.alu_mem_mode = MEMALU_OP_OFFSET; c.pc = REG_OP_READ; end
         default: c = c;
      endcase
      return c;
   endfunction

   // Monitor: one expected entry per cycle, checked mid-cycle.
   always @(negedge clk) begin
      exp_t  e;
      ctrl_t ec;
      if (q.size() != 0) begin
         e  = q.pop_front();
         ec = exp_ctrl(e.st);
         checks++;
         if (ctrl !== ec) begin
            failures++;
            $display("FAIL ctrl[%s] got=%h exp=%h", e.st.name(), ctrl, ec);
         end
         checks++;
         if (halted !== (e.st == HALT)) begin
            failures++;
            $display("FAIL halted[%s] got=%b exp=%b", e.st.name(), halted, (e.st == HALT));
         end
         checks++;
         if (illegal !== e.ill) begin
            failures++;
            $display("FAIL illegal[%s] got=%b exp=%b", e.st.name(), illegal, e.ill);
         end
`ifdef SEQ_RETIRE_CNT_EN
         checks++;
         if (retired !== e.ret) begin
            failures++;
            $display("FAIL retired[%s] got=%0d exp=%0d", e.st.name(), retired, e.ret);
         end
`endif
      end
   end

   task automatic cyc(input state_t st, input logic ill = 1'b0);
      exp_t e;
      @(posedge clk);
      #1;
      e.st  = st;
      e.ill = ill;
      e.ret = exp_ret;
      q.push_back(e);
   endtask

   task automatic fetch(input logic [OPW-1:0] op);
      instruction = op;
      cyc(FETCH_C);
      cyc(INCPC_A);
      cyc(INCPC_B);
   endtask

   task automatic retire(input logic ill = 1'b0);
      exp_ret = exp_ret + 1'b1;
      cyc(FETCH_A, ill);
   endtask

   initial begin
      reset = 1'b1;
      cyc(FETCH_A);
      cyc(FETCH_A);
      reset = 1'b0;

      fetch(5'h00); cyc(AST_L); retire();
      // ASTH with two stalled edges in FETCH_C
      instruction = 5'h01; mem_ready = 1'b0;
      cyc(FETCH_C); cyc(FETCH_C); cyc(FETCH_C);
      mem_ready = 1'b1;
      cyc(INCPC_A); cyc(INCPC_B); cyc(AST_H); retire();
      fetch(5'h02); cyc(MST_L); retire();
      fetch(5'h03); cyc(MST_H); retire();
      fetch(5'h04); cyc(OPER_A); cyc(OPER_B); retire();
      // LOD with memory not ready for three edges
      fetch(5'h09); cyc(LOD_A); cyc(LOD_B); cyc(LOD_C);
      mem_ready = 1'b0;
      cyc(LOD_C); cyc(LOD_C); cyc(LOD_C);
      mem_ready = 1'b1;
      retire();
      fetch(5'h0A); cyc(STO_A); cyc(STO_B); cyc(STO_C); retire();
      fetch(5'h0B); cyc(SWP_A); cyc(SWP_B); cyc(SWP_C); retire();
      fetch(5'h0C); cyc(MADD_A); cyc(MADD_B); retire();
      fetch(5'h06); cyc(JMP_A); cyc(JMP_B); retire();
      zero = 1'b0; overflow = 1'b1;
      fetch(5'h07); retire();
      zero = 1'b1; overflow = 1'b0;
      fetch(5'h07); cyc(JMP_A); cyc(JMP_B); retire();
      fetch(5'h08); retire();
      zero = 1'b0; overflow = 1'b1;
      fetch(5'h08); cyc(JMP_A); cyc(JMP_B); retire();
      overflow = 1'b0;
      // Undefined opcodes: low nibble 5, and nonzero upper bit
      fetch(5'h05); retire(1'b1);
      fetch(5'h00); cyc(AST_L); retire();
      fetch(5'h14); retire(1'b1);
      fetch(5'h00); cyc(AST_L); retire();
      fetch(5'h1F); retire(1'b1);
      fetch(5'h00); cyc(AST_L); retire();

      // Reset while STO_C waits on memory
      fetch(5'h0A); cyc(STO_A); cyc(STO_B);
      mem_ready = 1'b0;
      cyc(STO_C); cyc(STO_C);
      reset = 1'b1; exp_ret = '0;
      cyc(FETCH_A);
      reset = 1'b0; mem_ready = 1'b1;

      fetch(5'h0F);
      exp_ret = exp_ret + 1'b1;
      cyc(HALT);
      for (int i = 0; i < 10; i++) cyc(HALT);
      reset = 1'b1; exp_ret = '0;
      cyc(FETCH_A);
      reset = 1'b0;

      // Seventeen retires wrap a 4-bit counter to 1
      for (int i = 0; i < 17; i++) begin
         fetch(5'h00); cyc(AST_L); retire();
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
